// File: rtl/sd_clk_pkg.sv
// Shared state encoding and default sizing for the SD/eMMC card-clock generator.
package sd_clk_pkg;

  typedef enum logic [1:0] {OFF, STAB, READY, RUN} state_t;

  localparam int SD_DIV_W         = 10;
  localparam int SD_STABLE_CYCLES = 16;

  function automatic int stab_cnt_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

  localparam int SD_STAB_W = stab_cnt_w(SD_STABLE_CYCLES);

endpackage

// File: rtl/sd_clock_gen.sv
// Card clock = AXI_CLOCK / (2*(DIVISOR+1)) behind an internal-enable / stabilise / card-enable sequence.
// Start, stop and divisor reloads happen only at phase boundaries, so sd_clk never produces a runt pulse.
module sd_clock_gen
  import sd_clk_pkg::*;
#(
  parameter int DIV_W         = SD_DIV_W,
  parameter int STABLE_CYCLES = SD_STABLE_CYCLES
) (
  input  logic             AXI_CLOCK,
  input  logic             AXI_RST,
  input  logic [DIV_W-1:0] DIVISOR,
  input  logic             INT_CLK_EN,
  input  logic             SD_CLK_EN,
  output logic             sd_clk,
  output logic             Internal_clk_stable,
  output logic             sd_clk_active,
  output logic             sd_rise_pre,
  output logic             sd_fall_pre
);

  localparam int                STAB_W    = stab_cnt_w(STABLE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  state_t            w_stop_dst;
  logic              r_sd_clk;
  logic              w_sd_clk_nxt;
  logic              r_stable;
  logic              r_active;
  logic [DIV_W-1:0]  r_cnt;
  logic [DIV_W-1:0]  w_cnt_nxt;
  logic [DIV_W-1:0]  r_div_q;
  logic [DIV_W-1:0]  w_div_q_nxt;
  logic [STAB_W-1:0] r_stab_cnt;
  logic [STAB_W-1:0] w_stab_cnt_nxt;
  logic              w_toggle;
  logic              w_stop;

  assign w_toggle   = (r_cnt == r_div_q);
  assign w_stop     = ~SD_CLK_EN | ~INT_CLK_EN;
  assign w_stop_dst = INT_CLK_EN ? READY : OFF;

  always_comb begin
    w_state_nxt    = r_state;
    w_sd_clk_nxt   = r_sd_clk;
    w_cnt_nxt      = r_cnt;
    w_div_q_nxt    = r_div_q;
    w_stab_cnt_nxt = r_stab_cnt;
    case (r_state)
      OFF: begin
        if (INT_CLK_EN) begin
          w_state_nxt    = STAB;
          w_stab_cnt_nxt = '0;
        end
      end
      STAB: begin
        if (!INT_CLK_EN) begin
          w_state_nxt = OFF;
        end else if (r_stab_cnt == STAB_LAST) begin
          w_state_nxt = READY;
        end else begin
          w_stab_cnt_nxt = r_stab_cnt + STAB_W'(1);
        end
      end
      READY: begin
        if (!INT_CLK_EN) begin
          w_state_nxt = OFF;
        end else if (SD_CLK_EN) begin
          w_state_nxt  = RUN;
          w_div_q_nxt  = DIVISOR;
          w_cnt_nxt    = '0;
          w_sd_clk_nxt = 1'b0;
        end
      end
      RUN: begin
        if (w_toggle && r_sd_clk) begin
          // Falling edge closes a full period: the only safe point to reload or stop.
          w_sd_clk_nxt = 1'b0;
          w_cnt_nxt    = '0;
          w_div_q_nxt  = DIVISOR;
          if (w_stop) begin
            w_state_nxt = w_stop_dst;
          end
        end else if (!r_sd_clk && w_stop) begin
          // Low phase: stopping just stretches it, and beats a pending rise.
          w_state_nxt = w_stop_dst;
          w_cnt_nxt   = '0;
        end else if (w_toggle) begin
          w_sd_clk_nxt = 1'b1;
          w_cnt_nxt    = '0;
        end else begin
          w_cnt_nxt = r_cnt + DIV_W'(1);
        end
      end
      default: begin
        w_state_nxt = OFF;
      end
    endcase
  end

  always_ff @(posedge AXI_CLOCK) begin
    if (AXI_RST) begin
      r_state    <= OFF;
      r_sd_clk   <= 1'b0;
      r_stable   <= 1'b0;
      r_active   <= 1'b0;
      r_cnt      <= '0;
      r_stab_cnt <= '0;
      r_div_q    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_sd_clk   <= w_sd_clk_nxt;
      r_stable   <= (w_state_nxt == READY) || (w_state_nxt == RUN);
      r_active   <= (w_state_nxt == RUN);
      r_cnt      <= w_cnt_nxt;
      r_stab_cnt <= w_stab_cnt_nxt;
      r_div_q    <= w_div_q_nxt;
    end
  end

  assign sd_clk              = r_sd_clk;
  assign Internal_clk_stable = r_stable;
  assign sd_clk_active       = r_active;
  assign sd_rise_pre         = (r_state == RUN) & w_toggle & ~r_sd_clk & ~w_stop;
  assign sd_fall_pre         = (r_state == RUN) & w_toggle & r_sd_clk;

endmodule
